// File: rtl/scan_monitor_pkg.sv
// Shared types and helpers for the Larson scanner selection-bus monitor.
package scan_monitor_pkg;

  localparam int unsigned N_LINES = 16;
  localparam int unsigned POS_W   = 4;

  typedef enum logic [1:0] {
    StAcquire,
    StTrackUp,
    StTrackDown,
    StFault
  } scan_state_e;

  typedef enum logic [2:0] {
    ErrNone        = 3'd0,
    ErrNoneActive  = 3'd1,
    ErrMultiActive = 3'd2,
    ErrBadStep     = 3'd3,
    ErrBadReversal = 3'd4
  } scan_err_e;

  typedef enum logic [1:0] {
    StepUp,
    StepDown,
    StepBad
  } step_e;

  // Adjacency only; direction legality is judged by the caller.
  function automatic step_e classify_step(logic [POS_W-1:0] prev, logic [POS_W-1:0] code);
    if (prev != 4'd15 && code == prev + 4'd1) return StepUp;
    if (prev != 4'd0 && code == prev - 4'd1) return StepDown;
    return StepBad;
  endfunction

endpackage

// File: rtl/scan_monitor_if.sv
// Selection bus plus monitor status signals; master drives the bus, slave is the monitor.
interface scan_monitor_if #(
  parameter int unsigned SWEEP_W = 16
);
  import scan_monitor_pkg::*;

  logic [N_LINES-1:0] i_selection;
  logic               i_clr_err;
  logic [POS_W-1:0]   o_position;
  logic               o_dir;
  logic               o_locked;
  logic               o_fault;
  logic [2:0]         o_err_code;
  logic [POS_W-1:0]   o_err_pos;
  logic [SWEEP_W-1:0] o_sweep_count;

  modport master (
    output i_selection, i_clr_err,
    input  o_position, o_dir, o_locked, o_fault, o_err_code, o_err_pos, o_sweep_count
  );

  modport slave (
    input  i_selection, i_clr_err,
    output o_position, o_dir, o_locked, o_fault, o_err_code, o_err_pos, o_sweep_count
  );

endinterface

// File: rtl/scan_encoder_16to4.sv
// Active-low one-hot to 4-bit encoder with none/multiple-active detection.
module scan_encoder_16to4
  import scan_monitor_pkg::*;
(
  input  logic [N_LINES-1:0] sel_ni,
  output logic [POS_W-1:0]   code_o,
  output logic               valid_o,
  output logic               none_active_o,
  output logic               multi_active_o
);

  logic found;
  logic multi;

  always_comb begin
    code_o = '0;
    found  = 1'b0;
    multi  = 1'b0;
    for (int i = 0; i < N_LINES; i++) begin
      if (!sel_ni[i]) begin
        multi  = multi | found;
        found  = 1'b1;
        code_o = POS_W'(i);
      end
    end
    valid_o        = found & ~multi;
    none_active_o  = ~found;
    multi_active_o = multi;
  end

endmodule

// File: rtl/scan_monitor.sv
// Selection-bus monitor: decodes the scanner position, tracks the bounce and latches faults.
// Define SCAN_MONITOR_SWEEP_COUNT_EN to build the sweep counter; otherwise it reads as zero.
module scan_monitor
  import scan_monitor_pkg::*;
#(
  parameter int unsigned LOCK_STEPS = 4,
  parameter int unsigned SWEEP_W    = 16
) (
  input  logic         i_clk,
  input  logic         i_n_rst,
  scan_monitor_if.slave bus
);

  logic [N_LINES-1:0] sel_q, sel_d;

  logic [POS_W-1:0] enc_code;
  logic             enc_valid;
  logic             enc_none;
  logic             enc_multi;

  scan_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             dir_known_q, dir_known_d;
  logic             seeded_q, seeded_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  scan_err_e        err_code_q, err_code_d;
  logic [POS_W-1:0] err_pos_q, err_pos_d;
  logic             sweep_inc;

  step_e     step;
  logic      up_step, dn_step;
  logic      track_up;
  logic      bad_rev_track, bad_rev_acq;
  logic      acq_ok, lock_hit;
  scan_err_e track_err;

  always_comb sel_d = bus.i_selection;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) sel_q <= '1;
    else          sel_q <= sel_d;
  end

  scan_encoder_16to4 u_enc (
    .sel_ni         (sel_q),
    .code_o         (enc_code),
    .valid_o        (enc_valid),
    .none_active_o  (enc_none),
    .multi_active_o (enc_multi)
  );

  always_comb begin
    step     = classify_step(pos_q, enc_code);
    up_step  = (step == StepUp);
    dn_step  = (step == StepDown);
    track_up = (state_q == StTrackUp);
    // A step against the current direction is only legal as the bounce at 0 or 15.
    bad_rev_track = (up_step && !track_up && pos_q != 4'd0) ||
                    (dn_step && track_up && pos_q != 4'd15);
    bad_rev_acq   = dir_known_q && ((up_step && !dir_q && pos_q != 4'd0) ||
                                    (dn_step && dir_q && pos_q != 4'd15));
    acq_ok   = seeded_q && (step != StepBad) && !bad_rev_acq;
    lock_hit = (32'(lock_cnt_q) + 32'd1) >= LOCK_STEPS;

    if (enc_none)             track_err = ErrNoneActive;
    else if (enc_multi)       track_err = ErrMultiActive;
    else if (step == StepBad) track_err = ErrBadStep;
    else if (bad_rev_track)   track_err = ErrBadReversal;
    else                      track_err = ErrNone;
  end

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    dir_d       = dir_q;
    dir_known_d = dir_known_q;
    seeded_d    = seeded_q;
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;
    fault_d     = fault_q;
    err_code_d  = err_code_q;
    err_pos_d   = err_pos_q;
    sweep_inc   = 1'b0;

    case (state_q)
      StAcquire: begin
        if (enc_valid) begin
          pos_d    = enc_code;
          seeded_d = 1'b1;
        end
        if (enc_valid && acq_ok) begin
          dir_d       = up_step;
          dir_known_d = 1'b1;
          if (lock_hit) begin
            state_d    = up_step ? StTrackUp : StTrackDown;
            locked_d   = 1'b1;
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + 4'd1;
          end
        end else begin
          lock_cnt_d  = '0;
          dir_known_d = 1'b0;
        end
      end

      StTrackUp, StTrackDown: begin
        if (track_err != ErrNone) begin
          state_d    = StFault;
          fault_d    = 1'b1;
          locked_d   = 1'b0;
          err_code_d = track_err;
          err_pos_d  = pos_q;
          if (enc_valid) pos_d = enc_code;
        end else begin
          pos_d   = enc_code;
          dir_d   = up_step;
          state_d = up_step ? StTrackUp : StTrackDown;
          if (up_step != track_up) sweep_inc = 1'b1;
        end
      end

      StFault: begin
        if (enc_valid) pos_d = enc_code;
        // Clear wins over whatever this cycle's sample holds; a valid one becomes the seed.
        if (bus.i_clr_err) begin
          state_d     = StAcquire;
          fault_d     = 1'b0;
          err_code_d  = ErrNone;
          err_pos_d   = '0;
          lock_cnt_d  = '0;
          dir_known_d = 1'b0;
        end
      end

      default: state_d = StAcquire;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state_q     <= StAcquire;
      pos_q       <= '0;
      dir_q       <= 1'b1;
      dir_known_q <= 1'b0;
      seeded_q    <= 1'b0;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
      err_code_q  <= ErrNone;
      err_pos_q   <= '0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      dir_known_q <= dir_known_d;
      seeded_q    <= seeded_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
      err_code_q  <= err_code_d;
      err_pos_q   <= err_pos_d;
    end
  end

`ifdef SCAN_MONITOR_SWEEP_COUNT_EN
  logic [SWEEP_W-1:0] sweep_q, sweep_d;

  always_comb sweep_d = sweep_inc ? sweep_q + SWEEP_W'(1) : sweep_q;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) sweep_q <= '0;
    else          sweep_q <= sweep_d;
  end

  assign bus.o_sweep_count = sweep_q;
`else
  logic unused_sweep_inc;
  assign unused_sweep_inc  = sweep_inc;
  assign bus.o_sweep_count = '0;
`endif

  assign bus.o_position = pos_q;
  assign bus.o_dir      = dir_q;
  assign bus.o_locked   = locked_q;
  assign bus.o_fault    = fault_q;
  assign bus.o_err_code = err_code_q;
  assign bus.o_err_pos  = err_pos_q;

endmodule

// File: tb/tb_scan_monitor.sv
// Directed self-checking bench for scan_monitor: lock, faults, clear, acquire tolerance, reset.
module tb_scan_monitor;

`ifdef SCAN_MONITOR_SWEEP_COUNT_EN
  localparam int unsigned SweepPerRev = 1;
`else
  localparam int unsigned SweepPerRev = 0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  scan_monitor_if #(.SWEEP_W(16)) bus ();

  scan_monitor #(
    .LOCK_STEPS (4),
    .SWEEP_W    (16)
  ) dut (
    .i_clk   (clk),
    .i_n_rst (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] sel_of(input int pos);
    logic [15:0] one;
    one = 16'h0001;
    return ~(one << pos);
  endfunction

  // Legal bounce sequence starting at 0: 0..15, 14..1, 0, 1, ...
  function automatic int scan_p(input int i);
    int m;
    m = i % 30;
    return (m <= 15) ? m : 30 - m;
  endfunction

  // Drive one sample; afterwards the outputs reflect the previously fed sample.
  task automatic feed(input logic [15:0] sel, input logic clr);
    @(negedge clk);
    bus.i_selection = sel;
    bus.i_clr_err   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n           = 1'b0;
    bus.i_selection = 16'hFFFF;
    bus.i_clr_err   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    feed(16'hFFFF, 1'b0);
    feed(16'hFFFF, 1'b0);
    checks++;
    if (bus.o_position !== 4'd0 || bus.o_dir !== 1'b1 || bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_pos_dir_lock got %0d/%0d/%0d want 0/1/0",
               bus.o_position, bus.o_dir, bus.o_locked);
    end
    checks++;
    if (bus.o_fault !== 1'b0 || bus.o_err_code !== 3'd0 || bus.o_err_pos !== 4'd0 ||
        bus.o_sweep_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_err got %0d/%0d/%0d/%0d want 0/0/0/0",
               bus.o_fault, bus.o_err_code, bus.o_err_pos, bus.o_sweep_count);
    end
  endtask

  task automatic test_lock_scan();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      feed(sel_of(scan_p(i)), 1'b0);
      if (i >= 1) begin
        checks++;
        if (bus.o_position !== 4'(scan_p(i - 1))) begin
          errors++;
          $display("FAIL scan_pos[%0d] got %0d want %0d", i, bus.o_position, scan_p(i - 1));
        end
        checks++;
        if (bus.o_locked !== ((i - 1) >= 4)) begin
          errors++;
          $display("FAIL scan_locked[%0d] got %0d want %0d", i, bus.o_locked, (i - 1) >= 4);
        end
        checks++;
        if (bus.o_fault !== 1'b0) begin
          errors++;
          $display("FAIL scan_fault[%0d] got %0d want 0", i, bus.o_fault);
        end
      end
    end
    checks++;
    if (bus.o_sweep_count !== 16'(2 * SweepPerRev)) begin
      errors++;
      $display("FAIL scan_sweeps got %0d want %0d", bus.o_sweep_count, 2 * SweepPerRev);
    end
    checks++;
    if (bus.o_dir !== 1'b1) begin
      errors++;
      $display("FAIL scan_dir got %0d want 1", bus.o_dir);
    end
  endtask

  task automatic test_skip();
    do_reset();
    for (int i = 0; i <= 6; i++) feed(sel_of(i), 1'b0);
    feed(sel_of(8), 1'b0);
    checks++;
    if (bus.o_locked !== 1'b1 || bus.o_position !== 4'd6) begin
      errors++;
      $display("FAIL skip_pre got lock %0d pos %0d want 1/6", bus.o_locked, bus.o_position);
    end
    feed(sel_of(9), 1'b0);
    checks++;
    if (bus.o_fault !== 1'b1 || bus.o_err_code !== 3'd3 || bus.o_err_pos !== 4'd6 ||
        bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL skip_fault got %0d/%0d/%0d/%0d want 1/3/6/0",
               bus.o_fault, bus.o_err_code, bus.o_err_pos, bus.o_locked);
    end
  endtask

  task automatic test_reversal();
    do_reset();
    for (int i = 0; i <= 9; i++) feed(sel_of(i), 1'b0);
    feed(sel_of(8), 1'b0);
    feed(sel_of(7), 1'b0);
    checks++;
    if (bus.o_fault !== 1'b1 || bus.o_err_code !== 3'd4 || bus.o_err_pos !== 4'd9) begin
      errors++;
      $display("FAIL rev_fault got %0d/%0d/%0d want 1/4/9",
               bus.o_fault, bus.o_err_code, bus.o_err_pos);
    end
    feed(sel_of(6), 1'b1);
    checks++;
    if (bus.o_fault !== 1'b0 || bus.o_err_code !== 3'd0 || bus.o_err_pos !== 4'd0 ||
        bus.o_position !== 4'd7) begin
      errors++;
      $display("FAIL rev_clear got %0d/%0d/%0d pos %0d want 0/0/0 pos 7",
               bus.o_fault, bus.o_err_code, bus.o_err_pos, bus.o_position);
    end
    for (int p = 5; p >= 3; p--) feed(sel_of(p), 1'b0);
    checks++;
    if (bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL rev_early_lock got %0d want 0", bus.o_locked);
    end
    feed(sel_of(2), 1'b0);
    checks++;
    if (bus.o_locked !== 1'b1 || bus.o_dir !== 1'b0 || bus.o_position !== 4'd3) begin
      errors++;
      $display("FAIL rev_relock got lock %0d dir %0d pos %0d want 1/0/3",
               bus.o_locked, bus.o_dir, bus.o_position);
    end
  endtask

  task automatic test_bad_bus();
    do_reset();
    for (int i = 0; i <= 5; i++) feed(sel_of(i), 1'b0);
    feed(16'hFFFF, 1'b0);
    feed(sel_of(6), 1'b0);
    checks++;
    if (bus.o_fault !== 1'b1 || bus.o_err_code !== 3'd1 || bus.o_err_pos !== 4'd5) begin
      errors++;
      $display("FAIL none_fault got %0d/%0d/%0d want 1/1/5",
               bus.o_fault, bus.o_err_code, bus.o_err_pos);
    end
    feed(sel_of(7), 1'b1);
    checks++;
    if (bus.o_fault !== 1'b0 || bus.o_position !== 4'd6) begin
      errors++;
      $display("FAIL none_clear got fault %0d pos %0d want 0/6", bus.o_fault, bus.o_position);
    end
    for (int p = 8; p <= 11; p++) feed(sel_of(p), 1'b0);
    checks++;
    if (bus.o_locked !== 1'b1) begin
      errors++;
      $display("FAIL none_relock got %0d want 1", bus.o_locked);
    end
    feed(16'hFFF3, 1'b0);
    feed(sel_of(12), 1'b0);
    checks++;
    if (bus.o_fault !== 1'b1 || bus.o_err_code !== 3'd2 || bus.o_err_pos !== 4'd11) begin
      errors++;
      $display("FAIL multi_fault got %0d/%0d/%0d want 1/2/11",
               bus.o_fault, bus.o_err_code, bus.o_err_pos);
    end
  endtask

  task automatic test_acquire_tolerance();
    logic [15:0] seq [10];
    seq = '{sel_of(0), sel_of(1), sel_of(2), sel_of(2), 16'hFFFF,
            sel_of(3), sel_of(4), sel_of(5), sel_of(6), sel_of(7)};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      feed(seq[i], 1'b0);
      if (i == 5) begin
        checks++;
        if (bus.o_fault !== 1'b0 || bus.o_locked !== 1'b0 || bus.o_position !== 4'd2) begin
          errors++;
          $display("FAIL acq_glitch got fault %0d lock %0d pos %0d want 0/0/2",
                   bus.o_fault, bus.o_locked, bus.o_position);
        end
      end
      if (i == 8) begin
        checks++;
        if (bus.o_locked !== 1'b0) begin
          errors++;
          $display("FAIL acq_early_lock got %0d want 0", bus.o_locked);
        end
      end
    end
    checks++;
    if (bus.o_locked !== 1'b1 || bus.o_position !== 4'd6 || bus.o_dir !== 1'b1) begin
      errors++;
      $display("FAIL acq_lock got lock %0d pos %0d dir %0d want 1/6/1",
               bus.o_locked, bus.o_position, bus.o_dir);
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_reset();
    for (int i = 0; i <= 20; i++) feed(sel_of(scan_p(i)), 1'b0);
    checks++;
    if (bus.o_dir !== 1'b0 || bus.o_locked !== 1'b1 || bus.o_position !== 4'd11 ||
        bus.o_sweep_count !== 16'(SweepPerRev)) begin
      errors++;
      $display("FAIL mid_pre got dir %0d lock %0d pos %0d sweep %0d want 0/1/11/%0d",
               bus.o_dir, bus.o_locked, bus.o_position, bus.o_sweep_count, SweepPerRev);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_position !== 4'd0 || bus.o_dir !== 1'b1 || bus.o_locked !== 1'b0 ||
        bus.o_sweep_count !== 16'd0 || bus.o_fault !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got pos %0d dir %0d lock %0d sweep %0d fault %0d",
               bus.o_position, bus.o_dir, bus.o_locked, bus.o_sweep_count, bus.o_fault);
    end
    @(negedge clk);
    rst_n = 1'b1;
    feed(sel_of(5), 1'b0);
    feed(sel_of(6), 1'b0);
    checks++;
    if (bus.o_position !== 4'd5 || bus.o_fault !== 1'b0) begin
      errors++;
      $display("FAIL mid_seed got pos %0d fault %0d want 5/0", bus.o_position, bus.o_fault);
    end
  endtask

  task automatic test_clear_vs_fault();
    do_reset();
    for (int i = 0; i <= 6; i++) feed(sel_of(i), 1'b0);
    feed(sel_of(8), 1'b0);
    feed(16'hFFFF, 1'b0);
    checks++;
    if (bus.o_fault !== 1'b1 || bus.o_err_code !== 3'd3) begin
      errors++;
      $display("FAIL clr_pre got fault %0d code %0d want 1/3", bus.o_fault, bus.o_err_code);
    end
    feed(sel_of(3), 1'b1);
    checks++;
    if (bus.o_fault !== 1'b0 || bus.o_err_code !== 3'd0 || bus.o_locked !== 1'b0) begin
      errors++;
      $display("FAIL clr_wins got fault %0d code %0d lock %0d want 0/0/0",
               bus.o_fault, bus.o_err_code, bus.o_locked);
    end
    feed(sel_of(12), 1'b0);
    checks++;
    if (bus.o_fault !== 1'b0 || bus.o_position !== 4'd3) begin
      errors++;
      $display("FAIL clr_acquire got fault %0d pos %0d want 0/3", bus.o_fault, bus.o_position);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.i_selection = 16'hFFFF;
    bus.i_clr_err   = 1'b0;
    test_reset();
    test_lock_scan();
    test_skip();
    test_reversal();
    test_bad_bus();
    test_acquire_tolerance();
    test_reset_mid_sweep();
    test_clear_vs_fault();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
